// File: rtl/ard_pkg.sv
// ---------------------------------------------------------------------------
// Module : ard_pkg
// Brief  : Shared widths, address type and loader FSM state encoding.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ard_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GET_LO = 3'd1,
    ST_ACK_LO = 3'd2,
    ST_GET_HI = 3'd3,
    ST_ACK_HI = 3'd4,
    ST_WRITE  = 3'd5,
    ST_DONE   = 3'd6
  } ard_ld_state_t;

  typedef logic [ADDR_W-1:0] ard_addr_t;
endpackage

`default_nettype wire

// File: rtl/ard_sync.sv
// ---------------------------------------------------------------------------
// Module : ard_sync
// Brief  : SYNC_STAGES-deep flop chain bringing an async level into clk.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ard_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic asyncIn,
  output logic syncOut
);
  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_chain <= '0;
    else      r_chain <= {r_chain[SYNC_STAGES-2:0], asyncIn};
  end

  assign syncOut = r_chain[SYNC_STAGES-1];
endmodule

`default_nettype wire

// File: rtl/ard_ram_loader.sv
// ---------------------------------------------------------------------------
// Module : ard_ram_loader
// Brief  : Packs Arduino req/ack byte pairs into 16-bit RAM writes from a base
//          address. Optional ARD_LOADER_CHECKSUM_EN adds a running word sum.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ard_ram_loader #(
  parameter int ADDR_W      = ard_pkg::ADDR_W,
  parameter int DATA_W      = ard_pkg::DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              ard_req,
  input  logic [7:0]        ard_data,
  output logic              ard_ack,
  output logic [ADDR_W-1:0] arduinoAdd,
  output logic [DATA_W-1:0] arduinoW,
  output logic              ardwen,
  output logic              busy,
`ifdef ARD_LOADER_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic              done
);
  import ard_pkg::*;

  logic w_reqS;

  ard_sync #(.SYNC_STAGES(SYNC_STAGES)) u_reqSync (
    .clk     (clk),
    .rst     (rst),
    .asyncIn (ard_req),
    .syncOut (w_reqS)
  );

  ard_ld_state_t     r_state,  w_stateNext;
  logic [ADDR_W-1:0] r_addr,   w_addrNext;
  logic [ADDR_W-1:0] r_rem,    w_remNext;
  logic [7:0]        r_lo,     w_loNext;
  logic [7:0]        r_hi,     w_hiNext;
  logic [ADDR_W-1:0] r_wAdd,   w_wAddNext;
  logic [DATA_W-1:0] r_wData,  w_wDataNext;
  logic              r_ack,    w_ackNext;
  logic              r_wen,    w_wenNext;
  logic              r_busy,   w_busyNext;
  logic              r_done,   w_doneNext;
`ifdef ARD_LOADER_CHECKSUM_EN
  logic [15:0]       r_sum,    w_sumNext;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_wAdd  <= '0;
      r_wData <= '0;
      r_ack   <= 1'b0;
      r_wen   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef ARD_LOADER_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_state <= w_stateNext;
      r_addr  <= w_addrNext;
      r_rem   <= w_remNext;
      r_lo    <= w_loNext;
      r_hi    <= w_hiNext;
      r_wAdd  <= w_wAddNext;
      r_wData <= w_wDataNext;
      r_ack   <= w_ackNext;
      r_wen   <= w_wenNext;
      r_busy  <= w_busyNext;
      r_done  <= w_doneNext;
`ifdef ARD_LOADER_CHECKSUM_EN
      r_sum   <= w_sumNext;
`endif
    end
  end

  // Outputs are registered next-values so ard_ack toward the Arduino is glitch-free.
  always_comb begin
    w_stateNext = r_state;
    w_addrNext  = r_addr;
    w_remNext   = r_rem;
    w_loNext    = r_lo;
    w_hiNext    = r_hi;
    w_wAddNext  = r_wAdd;
    w_wDataNext = r_wData;
    w_ackNext   = r_ack;
    w_busyNext  = r_busy;
`ifdef ARD_LOADER_CHECKSUM_EN
    w_sumNext   = r_sum;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_addrNext  = base_addr;
          w_remNext   = word_count;
          w_busyNext  = 1'b1;
`ifdef ARD_LOADER_CHECKSUM_EN
          w_sumNext   = '0;
`endif
          w_stateNext = (word_count == '0) ? ST_DONE : ST_GET_LO;
        end
      end
      ST_GET_LO: if (w_reqS) begin
        w_loNext    = ard_data;
        w_ackNext   = 1'b1;
        w_stateNext = ST_ACK_LO;
      end
      ST_ACK_LO: if (!w_reqS) begin
        w_ackNext   = 1'b0;
        w_stateNext = ST_GET_HI;
      end
      ST_GET_HI: if (w_reqS) begin
        w_hiNext    = ard_data;
        w_ackNext   = 1'b1;
        w_stateNext = ST_ACK_HI;
      end
      ST_ACK_HI: if (!w_reqS) begin
        w_ackNext   = 1'b0;
        w_wAddNext  = r_addr;
        w_wDataNext = {r_hi, r_lo};
        w_stateNext = ST_WRITE;
      end
      ST_WRITE: begin
        w_addrNext  = r_addr + ADDR_W'(1);
        w_remNext   = r_rem - ADDR_W'(1);
`ifdef ARD_LOADER_CHECKSUM_EN
        w_sumNext   = r_sum + {r_hi, r_lo};
`endif
        w_stateNext = (r_rem == ADDR_W'(1)) ? ST_DONE : ST_GET_LO;
      end
      ST_DONE: begin
        w_busyNext  = 1'b0;
        w_stateNext = ST_IDLE;
      end
      default: w_stateNext = ST_IDLE;
    endcase
    w_wenNext  = (w_stateNext == ST_WRITE);
    w_doneNext = (w_stateNext == ST_DONE);
  end

  assign ard_ack    = r_ack;
  assign arduinoAdd = r_wAdd;
  assign arduinoW   = r_wData;
  assign ardwen     = r_wen;
  assign busy       = r_busy;
  assign done       = r_done;
`ifdef ARD_LOADER_CHECKSUM_EN
  assign checksum   = r_sum;
`endif
endmodule

`default_nettype wire

// File: tb/tb_ard_ram_loader.sv
// ---------------------------------------------------------------------------
// Module : tb_ard_ram_loader
// Brief  : Scoreboard bench for ard_ram_loader with an Arduino req/ack driver.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ard_ram_loader;
  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, ard_req = 1'b0;
  logic [19:0] base_addr = '0, word_count = '0;
  logic [7:0]  ard_data = '0;
  logic        ard_ack, ardwen, busy, done;
  logic [19:0] arduinoAdd;
  logic [15:0] arduinoW;
`ifdef ARD_LOADER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  ard_ram_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .ard_req(ard_req), .ard_data(ard_data),
    .ard_ack(ard_ack), .arduinoAdd(arduinoAdd), .arduinoW(arduinoW),
    .ardwen(ardwen), .busy(busy),
`ifdef ARD_LOADER_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [19:0] a; logic [15:0] d; } wr_t;
  wr_t         expQ[$];
  wr_t         expItem;
  logic [15:0] mem [logic [19:0]];
  int checks = 0, errors = 0, wrCnt = 0, doneCnt = 0;
  bit ackSeen = 1'b0;

  // Scoreboard: every observed RAM write must match the oldest queued word.
  always @(negedge clk) begin
    if (ard_ack === 1'b1) ackSeen = 1'b1;
    if (done === 1'b1) doneCnt++;
    if (ardwen === 1'b1) begin
      wrCnt++;
      mem[arduinoAdd] = arduinoW;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", arduinoAdd, arduinoW);
      end else begin
        expItem = expQ.pop_front();
        if ({arduinoAdd, arduinoW} !== expItem) begin
          errors++;
          $display("FAIL write addr=%h data=%h expected addr=%h data=%h",
                   arduinoAdd, arduinoW, expItem.a, expItem.d);
        end
      end
    end
  end

  task automatic pulse_start(input logic [19:0] b, input logic [19:0] c);
    @(posedge clk) #1;
    base_addr = b; word_count = c; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
  endtask

  task automatic wait_ack(input logic v);
    int n = 0;
    while (ard_ack !== v && n < 20) begin @(negedge clk); n++; end
    if (ard_ack !== v) begin
      checks++; errors++;
      $display("FAIL ack_timeout ard_ack=%b expected=%b", ard_ack, v);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk) #2;
    ard_data = b; ard_req = 1'b1;
    wait_ack(1'b1);
    @(posedge clk) #2;
    ard_req = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic send_word(input logic [19:0] a, input logic [15:0] d);
    expQ.push_back({a, d});
    send_byte(d[7:0]);
    send_byte(d[15:8]);
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout done=%b expected=1", done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 6;
    if (ard_ack !== 1'b0)     begin errors++; $display("FAIL rst_ack got=%b exp=0", ard_ack); end
    if (ardwen !== 1'b0)      begin errors++; $display("FAIL rst_wen got=%b exp=0", ardwen); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (done !== 1'b0)        begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
    if (arduinoAdd !== 20'h0) begin errors++; $display("FAIL rst_add got=%h exp=0", arduinoAdd); end
    if (arduinoW !== 16'h0)   begin errors++; $display("FAIL rst_w got=%h exp=0", arduinoW); end
    rst = 1'b1;
  endtask

  task automatic test_single();
    int w0 = wrCnt, d0 = doneCnt;
    pulse_start(20'h00010, 20'd1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", busy); end
    send_word(20'h00010, 16'h1234);
    wait_done();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
    repeat (4) @(negedge clk);
    checks += 4;
    if (wrCnt - w0 != 1)   begin errors++; $display("FAIL single_writes got=%0d exp=1", wrCnt - w0); end
    if (doneCnt - d0 != 1) begin errors++; $display("FAIL single_done got=%0d exp=1", doneCnt - d0); end
    if (arduinoAdd !== 20'h00010) begin errors++; $display("FAIL single_add_hold got=%h exp=00010", arduinoAdd); end
    if (arduinoW !== 16'h1234)    begin errors++; $display("FAIL single_w_hold got=%h exp=1234", arduinoW); end
  endtask

  task automatic test_burst();
    pulse_start(20'h00000, 20'd4);
    for (int i = 0; i < 4; i++) send_word(20'(i), 16'(i + 1));
    wait_done();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[20'(i)] !== 16'(i + 1)) begin
        errors++;
        $display("FAIL burst_mem addr=%0d got=%h exp=%h", i, mem[20'(i)], 16'(i + 1));
      end
    end
  endtask

  task automatic test_wrap();
    pulse_start(20'hFFFFF, 20'd2);
    send_word(20'hFFFFF, 16'hBEEF);
    send_word(20'h00000, 16'hCAFE);
    wait_done();
    checks += 2;
    if (mem[20'hFFFFF] !== 16'hBEEF) begin errors++; $display("FAIL wrap_hi got=%h exp=beef", mem[20'hFFFFF]); end
    if (mem[20'h00000] !== 16'hCAFE) begin errors++; $display("FAIL wrap_lo got=%h exp=cafe", mem[20'h00000]); end
  endtask

  task automatic test_zero();
    int w0 = wrCnt;
    repeat (2) @(negedge clk);
    ackSeen = 1'b0;
    pulse_start(20'h00055, 20'd0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", done); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_len got=%b exp=0", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    checks += 2;
    if (wrCnt != w0)     begin errors++; $display("FAIL zero_writes got=%0d exp=%0d", wrCnt, w0); end
    if (ackSeen !== 1'b0) begin errors++; $display("FAIL zero_ack got=%b exp=0", ackSeen); end
  endtask

  task automatic test_restart_ignored();
    int w0 = wrCnt, d0 = doneCnt;
    pulse_start(20'h00100, 20'd1);
    pulse_start(20'h00200, 20'd3);
    send_word(20'h00100, 16'h5A5A);
    wait_done();
    repeat (10) @(negedge clk);
    checks += 2;
    if (wrCnt - w0 != 1)   begin errors++; $display("FAIL restart_writes got=%0d exp=1", wrCnt - w0); end
    if (doneCnt - d0 != 1) begin errors++; $display("FAIL restart_done got=%0d exp=1", doneCnt - d0); end
  endtask

  task automatic test_reset_mid();
    int w0 = wrCnt;
    pulse_start(20'h00040, 20'd1);
    send_byte(8'h77);
    #2 rst = 1'b0;
    #1;
    checks += 2;
    if (ard_ack !== 1'b0) begin errors++; $display("FAIL midrst_ack got=%b exp=0", ard_ack); end
    if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (wrCnt != w0) begin errors++; $display("FAIL midrst_writes got=%0d exp=%0d", wrCnt, w0); end
    pulse_start(20'h00041, 20'd1);
    send_word(20'h00041, 16'h9988);
    wait_done();
  endtask

`ifdef ARD_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulse_start(20'h00300, 20'd2);
    send_word(20'h00300, 16'hFFFF);
    send_word(20'h00301, 16'h0002);
    wait_done();
    checks++;
    if (checksum !== 16'h0001) begin errors++; $display("FAIL checksum got=%h exp=0001", checksum); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_wrap();
    test_zero();
    test_restart_ignored();
    test_reset_mid();
`ifdef ARD_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (5) @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin errors++; $display("FAIL pending_writes got=%0d exp=0", expQ.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
